// File: rtl/key_click_detector_if.sv
// Bundles the debouncer-side press strobe and the click-classification outputs.
interface key_click_detector_if #(
   parameter int unsigned PRESS_CNT_W = 8
) ();
   logic                   key_pressed_stb_i;
   logic                   single_click_stb_o;
   logic                   double_click_stb_o;
   logic                   busy_o;
   logic [PRESS_CNT_W-1:0] press_cnt_o;

   modport slave (
      input  key_pressed_stb_i,
      output single_click_stb_o,
      output double_click_stb_o,
      output busy_o,
      output press_cnt_o
   );

   modport master (
      output key_pressed_stb_i,
      input  single_click_stb_o,
      input  double_click_stb_o,
      input  busy_o,
      input  press_cnt_o
   );
endinterface

// File: rtl/key_click_detector.sv
// Classifies debounced key presses as single or double clicks within a tick window
// and keeps a wrap-around count of every press.
module key_click_detector #(
   parameter int unsigned CLK_FREQ_MHZ           = 150,
   parameter int unsigned DOUBLE_CLICK_WINDOW_US = 300,
   parameter int unsigned PRESS_CNT_W            = 8
) (
   input  logic                 clk_i,
   input  logic                 srst_i,
   key_click_detector_if.slave  bus
);
   localparam int unsigned W     = CLK_FREQ_MHZ * DOUBLE_CLICK_WINDOW_US;
   localparam int unsigned TMR_W = $clog2(W + 1);

   if (W < 1) begin : g_window_check
      $error("key_click_detector: double-click window must be at least one tick");
   end

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic                   single_q, single_d;
   logic                   double_q, double_d;
   logic                   busy_q, busy_d;
   logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;

   logic stb;
   assign stb = bus.key_pressed_stb_i;

   // Next-state and output logic; a press on the last window tick beats expiry.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      single_d    = 1'b0;
      double_d    = 1'b0;
      press_cnt_d = press_cnt_q;

      if (stb) begin
         press_cnt_d = press_cnt_q + PRESS_CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (stb) begin
               state_d = WAIT;
               timer_d = TMR_W'(W - 1);
            end
         end
         WAIT: begin
            if (stb) begin
               double_d = 1'b1;
               state_d  = IDLE;
               timer_d  = '0;
            end else if (timer_q == '0) begin
               single_d = 1'b1;
               state_d  = IDLE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase

      busy_d = (state_d == WAIT);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         single_q    <= 1'b0;
         double_q    <= 1'b0;
         busy_q      <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         single_q    <= single_d;
         double_q    <= double_d;
         busy_q      <= busy_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign bus.single_click_stb_o = single_q;
   assign bus.double_click_stb_o = double_q;
   assign bus.busy_o             = busy_q;
   assign bus.press_cnt_o        = press_cnt_q;
endmodule
